// File: rtl/btb_predictor_if.sv
// Fetch/resolve/flush signal bundle between the pipeline and btb_predictor.
// master = pipeline side, slave = predictor side.
interface btb_predictor_if;
   logic [31:0] fetch_pc;
   logic [31:0] next_pc;
   logic        pred_taken;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        flush_req;
   logic        busy;
   logic [31:0] stat_hits;
   logic [31:0] stat_mispred;

   modport master (
      output fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, flush_req,
      input  next_pc, pred_taken, busy, stat_hits, stat_mispred
   );

   modport slave (
      input  fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, flush_req,
      output next_pc, pred_taken, busy, stat_hits, stat_mispred
   );
endinterface

// File: rtl/btb_predictor.sv
// Branch target buffer / next-PC predictor with a one-entry-per-cycle flush sweep.
// Hit and mispredict counters are built only when BTB_STATS_EN is defined.
module btb_predictor #(
   parameter int unsigned ENTRIES = 32
) (
   input logic            clk,
   input logic            rst,
   btb_predictor_if.slave bus
);
   localparam int unsigned IDXW = $clog2(ENTRIES);
   localparam int unsigned TAGW = 32 - IDXW;

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t             state_q;
   logic               busy_q;
   logic [IDXW-1:0]    sweep_idx_q;
   logic [ENTRIES-1:0] valid_q;
   logic [TAGW-1:0]    tag_q    [ENTRIES];
   logic [31:0]        target_q [ENTRIES];
   logic [1:0]         ctr_q    [ENTRIES];

   logic [IDXW-1:0] look_idx;
   logic [TAGW-1:0] look_tag;
   logic            look_hit;
   logic [IDXW-1:0] upd_idx;
   logic [TAGW-1:0] upd_tag;
   logic            upd_hit;
   logic            upd_accept;

   always_comb begin
      look_idx       = bus.fetch_pc[IDXW-1:0];
      look_tag       = bus.fetch_pc[31:IDXW];
      look_hit       = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
      bus.pred_taken = look_hit && ctr_q[look_idx][1] && !busy_q;
      bus.next_pc    = bus.pred_taken ? target_q[look_idx] : bus.fetch_pc + 32'd1;
      bus.busy       = busy_q;
   end

   // Updates are only taken in IDLE, and a coincident flush request wins.
   always_comb begin
      upd_idx    = bus.upd_pc[IDXW-1:0];
      upd_tag    = bus.upd_pc[31:IDXW];
      upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
      upd_accept = (state_q == IDLE) && bus.upd_valid && !bus.flush_req;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         sweep_idx_q <= '0;
         valid_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.flush_req) begin
                  state_q     <= SWEEP;
                  busy_q      <= 1'b1;
                  sweep_idx_q <= '0;
               end else if (upd_accept && !upd_hit && bus.upd_taken) begin
                  valid_q[upd_idx] <= 1'b1;
               end
            end
            SWEEP: begin
               valid_q[sweep_idx_q] <= 1'b0;
               sweep_idx_q          <= sweep_idx_q + IDXW'(1);
               if (sweep_idx_q == IDXW'(ENTRIES - 1)) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Payload fields are not reset; valid_q alone gates their use.
   always_ff @(posedge clk) begin
      if (!rst && upd_accept) begin
         if (upd_hit) begin
            if (bus.upd_taken) begin
               if (ctr_q[upd_idx] != 2'b11) ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
               target_q[upd_idx] <= bus.upd_target;
            end else if (ctr_q[upd_idx] != 2'b00) begin
               ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
            end
         end else if (bus.upd_taken) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= bus.upd_target;
            ctr_q[upd_idx]    <= 2'b10;
         end
      end
   end

`ifdef BTB_STATS_EN
   logic        upd_mispred;
   logic [31:0] hits_q;
   logic [31:0] mispred_q;

   always_comb begin
      upd_mispred = upd_hit ? (ctr_q[upd_idx][1] != bus.upd_taken) : bus.upd_taken;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hits_q    <= '0;
         mispred_q <= '0;
      end else begin
         if (look_hit && !busy_q && hits_q != '1) hits_q <= hits_q + 32'd1;
         if (upd_accept && upd_mispred && mispred_q != '1) mispred_q <= mispred_q + 32'd1;
      end
   end

   assign bus.stat_hits    = hits_q;
   assign bus.stat_mispred = mispred_q;
`else
   assign bus.stat_hits    = '0;
   assign bus.stat_mispred = '0;
`endif
endmodule

// File: tb/tb_btb_predictor.sv
// Directed self-checking bench for btb_predictor (ENTRIES=32); stat expectations
// follow BTB_STATS_EN.
module tb_btb_predictor;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int unsigned checks = 0;
   int unsigned errors = 0;

   btb_predictor_if bus ();

   btb_predictor #(.ENTRIES(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
      bus.upd_valid  = 1'b1;
      bus.upd_pc     = pc;
      bus.upd_taken  = taken;
      bus.upd_target = tgt;
      cyc();
      bus.upd_valid = 1'b0;
   endtask

   task automatic look(input string tag, input logic [31:0] pc, input logic exp_taken,
                       input logic [31:0] exp_next);
      bus.fetch_pc = pc;
      #1;
      chk({tag, "_taken"}, 32'(bus.pred_taken), 32'(exp_taken));
      chk({tag, "_next"}, bus.next_pc, exp_next);
   endtask

   logic [31:0] exp_hits;
   logic [31:0] exp_mis;

   initial begin
      bus.fetch_pc   = 32'h10;
      bus.upd_valid  = 1'b0;
      bus.upd_pc     = '0;
      bus.upd_taken  = 1'b0;
      bus.upd_target = '0;
      bus.flush_req  = 1'b0;

      // reset state
      cyc();
      look("rst", 32'h10, 1'b0, 32'h11);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_hits", bus.stat_hits, 32'd0);
      chk("rst_mis", bus.stat_mispred, 32'd0);
      rst = 1'b0;
      cyc();

      // allocate; same-cycle lookup sees old contents
      bus.upd_valid = 1'b1; bus.upd_pc = 32'h10; bus.upd_taken = 1'b1; bus.upd_target = 32'h40;
      #1;
      chk("nobypass", 32'(bus.pred_taken), 32'd0);
      cyc();
      bus.upd_valid = 1'b0;
      look("alloc", 32'h10, 1'b1, 32'h40);

      upd(32'h10, 1'b0, 32'h0);                 // ctr 2 -> 1
      look("nt1", 32'h10, 1'b0, 32'h11);
      upd(32'h10, 1'b1, 32'h44);                // 1 -> 2
      upd(32'h10, 1'b1, 32'h44);                // 2 -> 3
      upd(32'h10, 1'b1, 32'h44);                // saturate at 3
      look("sat3", 32'h10, 1'b1, 32'h44);
      upd(32'h10, 1'b0, 32'h0);                 // 3 -> 2
      look("sat3_nt", 32'h10, 1'b1, 32'h44);
      upd(32'h10, 1'b0, 32'h0);                 // 2 -> 1
      upd(32'h10, 1'b0, 32'h0);                 // 1 -> 0
      upd(32'h10, 1'b0, 32'h0);                 // saturate at 0
      look("sat0", 32'h10, 1'b0, 32'h11);
      upd(32'h10, 1'b1, 32'h44);
      upd(32'h10, 1'b1, 32'h44);                // back to 2
      look("recover", 32'h10, 1'b1, 32'h44);

      look("wrap", 32'hFFFF_FFFF, 1'b0, 32'h0);

      // aliasing entry 16
      look("alias_miss", 32'h30, 1'b0, 32'h31);
      upd(32'h30, 1'b1, 32'h80);
      look("evicted", 32'h10, 1'b0, 32'h11);
      look("alias_hit", 32'h30, 1'b1, 32'h80);
      upd(32'h50, 1'b0, 32'h0);                 // miss not-taken: no change
      look("miss_nt", 32'h30, 1'b1, 32'h80);
      upd(32'h05, 1'b1, 32'h99);
      look("e5", 32'h05, 1'b1, 32'h99);

      // flush with a coincident update (dropped)
      bus.flush_req = 1'b1;
      bus.upd_valid = 1'b1; bus.upd_pc = 32'h07; bus.upd_taken = 1'b1; bus.upd_target = 32'h77;
      cyc();
      bus.flush_req = 1'b0;
      bus.upd_valid = 1'b0;
      bus.fetch_pc  = 32'h30;
      for (int i = 0; i < 32; i++) begin
         if (i == 10) begin
            bus.upd_valid = 1'b1; bus.upd_pc = 32'h1F; bus.upd_taken = 1'b1; bus.upd_target = 32'h66;
         end
         if (i == 12) bus.flush_req = 1'b1;
         #1;
         chk($sformatf("sweep_busy%0d", i), 32'(bus.busy), 32'd1);
         chk($sformatf("sweep_pred%0d", i), 32'(bus.pred_taken), 32'd0);
         cyc();
         bus.upd_valid = 1'b0;
         bus.flush_req = 1'b0;
      end
      chk("sweep_done", 32'(bus.busy), 32'd0);
      look("post_30", 32'h30, 1'b0, 32'h31);
      look("post_05", 32'h05, 1'b0, 32'h06);
      look("post_07", 32'h07, 1'b0, 32'h08);
      look("post_1f", 32'h1F, 1'b0, 32'h20);
      upd(32'h08, 1'b1, 32'h88);                // first post-flush update accepted
      look("post_upd", 32'h08, 1'b1, 32'h88);

      // reset in the middle of a sweep
      upd(32'h09, 1'b1, 32'h90);
      bus.flush_req = 1'b1;
      cyc();
      bus.flush_req = 1'b0;
      for (int i = 0; i < 4; i++) cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      look("midrst_08", 32'h08, 1'b0, 32'h09);
      look("midrst_09", 32'h09, 1'b0, 32'h0A);
      upd(32'h0A, 1'b1, 32'hA0);
      look("midrst_upd", 32'h0A, 1'b1, 32'hA0);

      // statistics from a clean reset
      bus.fetch_pc = 32'h3FF;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("st_rst_hits", bus.stat_hits, 32'd0);
      chk("st_rst_mis", bus.stat_mispred, 32'd0);
      upd(32'h10, 1'b1, 32'h40);
      bus.fetch_pc = 32'h10;
      cyc(); cyc(); cyc();
      bus.fetch_pc = 32'h3FF;
      upd(32'h10, 1'b0, 32'h0);
`ifdef BTB_STATS_EN
      exp_hits = 32'd3;
      exp_mis  = 32'd2;
`else
      exp_hits = 32'd0;
      exp_mis  = 32'd0;
`endif
      chk("stat_hits", bus.stat_hits, exp_hits);
      chk("stat_mis", bus.stat_mispred, exp_mis);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
